// File: rtl/db_addr_gen_pkg.sv
// Shared types and constants for the multi-dimensional address generator.
package db_addr_gen_pkg;

  localparam int NUM_DIMS = 6;
  localparam int ADDR_W   = 16;
  localparam int RANGE_W  = 32;
  localparam int DIM_W    = 4;

  typedef logic [NUM_DIMS-1:0][ADDR_W-1:0]  stride_arr_t;
  typedef logic [NUM_DIMS-1:0][RANGE_W-1:0] range_arr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Clamp the requested loop depth into 1..NUM_DIMS.
  function automatic logic [DIM_W-1:0] eff_dims(input logic [DIM_W-1:0] d);
    if (d == '0)
      return DIM_W'(1);
    else if (d > DIM_W'(NUM_DIMS))
      return DIM_W'(NUM_DIMS);
    else
      return d;
  endfunction

endpackage

// File: rtl/db_dim_counter.sv
// One loop dimension: trip counter, wrap flag and running offset (cnt*stride).
module db_dim_counter
  import db_addr_gen_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [RANGE_W-1:0] range_m1_in,
  input  logic [ADDR_W-1:0]  stride_in,
  output logic               at_max,
  output logic [ADDR_W-1:0]  offset_nxt
);

  logic [RANGE_W-1:0] cnt_q;
  logic [RANGE_W-1:0] range_m1_q;
  logic [ADDR_W-1:0]  stride_q;
  logic [ADDR_W-1:0]  offset_q;

  assign at_max = (cnt_q == range_m1_q);

  // Offset this dimension will hold after the current cycle; wraps to 0 with the count.
  always_comb begin
    offset_nxt = offset_q;
    if (step)
      offset_nxt = at_max ? '0 : offset_q + stride_q;
  end

  // Latch config on load, advance or wrap on step.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      range_m1_q <= '0;
      stride_q   <= '0;
      offset_q   <= '0;
    end else if (load) begin
      cnt_q      <= '0;
      range_m1_q <= range_m1_in;
      stride_q   <= stride_in;
      offset_q   <= '0;
    end else if (step) begin
      cnt_q    <= at_max ? '0 : cnt_q + RANGE_W'(1);
      offset_q <= offset_nxt;
    end
  end

endmodule

// File: rtl/db_addr_gen.sv
// Nested-loop address generator with valid/ready output and double-buffer switch pulse.
module db_addr_gen
  import db_addr_gen_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              start,
  input  logic [ADDR_W-1:0] starting_addr,
  input  logic [DIM_W-1:0]  dimensionality,
  input  stride_arr_t       stride,
  input  range_arr_t        range,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              done,
  output logic              switch_db,
  output logic [31:0]       xfer_cnt
);

  state_t                          state, state_nxt;
  logic                            load;
  logic                            xfer;
  logic                            last;
  logic [ADDR_W-1:0]               base_q;
  logic [ADDR_W-1:0]               addr_nxt;
  logic [DIM_W-1:0]                dim_eff;
  logic [NUM_DIMS-1:0]             step;
  logic [NUM_DIMS-1:0]             at_max;
  logic [NUM_DIMS-1:0][ADDR_W-1:0] offset_nxt;
  logic [NUM_DIMS-1:0][RANGE_W-1:0] range_m1;

  assign dim_eff = eff_dims(dimensionality);

  // Per-dim terminal count; inactive dims and zero ranges collapse to a single trip.
  always_comb begin
    range_m1 = '0;
    for (int i = 0; i < NUM_DIMS; i++) begin
      if (DIM_W'(i) < dim_eff && range[i] != '0)
        range_m1[i] = range[i] - RANGE_W'(1);
    end
  end

  // Handshake qualification; flush pre-empts any transfer in the same cycle.
  assign xfer = clk_en && (state == ST_RUN) && addr_ready && !flush;
  assign last = xfer && (&at_max);

  // Carry chain: a dimension steps only when every inner dimension wraps.
  always_comb begin
    step[0] = xfer;
    for (int i = 1; i < NUM_DIMS; i++)
      step[i] = step[i-1] && at_max[i-1];
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIMS; g++) begin : g_dim
      db_dim_counter u_dim (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .step        (step[g]),
        .range_m1_in (range_m1[g]),
        .stride_in   (stride[g]),
        .at_max      (at_max[g]),
        .offset_nxt  (offset_nxt[g])
      );
    end
  endgenerate

  // Next address from the post-step offsets, so addr_out is registered with no bubble.
  always_comb begin
    addr_nxt = base_q;
    for (int i = 0; i < NUM_DIMS; i++)
      addr_nxt = addr_nxt + offset_nxt[i];
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clk_en && start && !flush) begin
          state_nxt = ST_RUN;
          load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (clk_en && flush)
          state_nxt = ST_IDLE;
        else if (last)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; everything freezes while clk_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      done       <= 1'b0;
      switch_db  <= 1'b0;
      xfer_cnt   <= '0;
    end else if (clk_en) begin
      state     <= state_nxt;
      done      <= 1'b0;
      switch_db <= 1'b0;
      if (flush) begin
        addr_valid <= 1'b0;
      end else if (load) begin
        base_q     <= starting_addr;
        addr_out   <= starting_addr;
        addr_valid <= 1'b1;
        xfer_cnt   <= '0;
      end else if (xfer) begin
        xfer_cnt <= xfer_cnt + 32'd1;
        if (last) begin
          addr_valid <= 1'b0;
          done       <= 1'b1;
          switch_db  <= 1'b1;
        end else begin
          addr_out <= addr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_db_addr_gen.sv
// Bench for db_addr_gen: table vectors, hand-written corner sequences, random patterns.
module tb_db_addr_gen;
  import db_addr_gen_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              clk_en;
  logic              flush;
  logic              start;
  logic [ADDR_W-1:0] starting_addr;
  logic [DIM_W-1:0]  dimensionality;
  stride_arr_t       stride;
  range_arr_t        rng;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              addr_ready;
  logic              done;
  logic              switch_db;
  logic [31:0]       xfer_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]      base;
    logic [3:0]       dim;
    logic [5:0][15:0] str;
    logic [5:0][31:0] rg;
    int               mode;       // 0: ready=1, 1: ready toggles 1,0, 2: random
    int               freeze_at;  // transfer index at which clk_en drops for 3 cycles, -1 none
    int               exp_count;
    logic [15:0]      exp_last;
  } vec_t;

  vec_t tbl[9];

  db_addr_gen dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .flush          (flush),
    .start          (start),
    .starting_addr  (starting_addr),
    .dimensionality (dimensionality),
    .stride         (stride),
    .range          (rng),
    .addr_out       (addr_out),
    .addr_valid     (addr_valid),
    .addr_ready     (addr_ready),
    .done           (done),
    .switch_db      (switch_db),
    .xfer_cnt       (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: number of active loops after clamping.
  function automatic int m_dims(input vec_t v);
    if (v.dim == 0) return 1;
    if (v.dim > 6) return 6;
    return int'(v.dim);
  endfunction

  function automatic longint m_range(input vec_t v, input int i);
    if (i >= m_dims(v)) return 1;
    if (v.rg[i] == 0) return 1;
    return longint'(v.rg[i]);
  endfunction

  function automatic int m_total(input vec_t v);
    longint t = 1;
    for (int i = 0; i < 6; i++) t = t * m_range(v, i);
    return int'(t);
  endfunction

  // Address of the n-th element: mixed-radix digits of n weighted by the strides.
  function automatic logic [15:0] m_addr(input vec_t v, input int n);
    longint rem = n;
    longint acc = longint'(v.base);
    for (int i = 0; i < 6; i++) begin
      longint r = m_range(v, i);
      acc = acc + (rem % r) * longint'(v.str[i]);
      rem = rem / r;
    end
    return acc[15:0];
  endfunction

  function automatic vec_t mk(input logic [15:0] base, input logic [3:0] dim, input int mode,
                              input int frz, input int cnt, input logic [15:0] last);
    vec_t v;
    v.base = base; v.dim = dim; v.str = '0; v.rg = '0;
    v.mode = mode; v.freeze_at = frz; v.exp_count = cnt; v.exp_last = last;
    return v;
  endfunction

  task automatic apply_cfg(input vec_t v);
    starting_addr  = v.base;
    dimensionality = v.dim;
    stride         = v.str;
    rng            = v.rg;
  endtask

  task automatic scramble_cfg();
    starting_addr  = 16'($urandom);
    dimensionality = 4'($urandom);
    for (int i = 0; i < 6; i++) begin
      stride[i] = 16'($urandom);
      rng[i]    = $urandom;
    end
  endtask

  // Launch a pattern and follow it to completion, checking every presented address.
  task automatic run_pattern(input vec_t v, input string nm);
    int total;
    int idx;
    int cyc;
    bit frozen;
    bit r;
    logic [15:0] last_addr;
    total = m_total(v);
    idx = 0; cyc = 0; frozen = 0; last_addr = '0;
    apply_cfg(v);
    flush = 0; addr_ready = 0; start = 1;
    tick();
    start = 0;
    scramble_cfg();
    while (idx < total && cyc < total * 4 + 20) begin
      if (v.freeze_at == idx && !frozen) begin
        frozen = 1;
        clk_en = 0;
        addr_ready = 1;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk({nm, "_frz_addr"}, 32'(addr_out), 32'(m_addr(v, idx)));
          chk({nm, "_frz_cnt"}, xfer_cnt, 32'(idx));
          chk({nm, "_frz_vld"}, 32'(addr_valid), 32'd1);
        end
        clk_en = 1;
      end
      case (v.mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2) == 0;
        default: r = 1'($urandom);
      endcase
      chk({nm, "_vld"}, 32'(addr_valid), 32'd1);
      chk({nm, "_addr"}, 32'(addr_out), 32'(m_addr(v, idx)));
      chk({nm, "_cnt"}, xfer_cnt, 32'(idx));
      chk({nm, "_done_low"}, 32'(done), 32'd0);
      if (r && idx == total - 1) last_addr = addr_out;
      start = 1'($urandom);
      addr_ready = r;
      tick();
      cyc++;
      if (r) idx++;
    end
    if (idx < total) begin
      errors++;
      $display("FAIL %s_timeout: transfers %0d required %0d", nm, idx, total);
    end
    start = 0;
    addr_ready = 0;
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_switch"}, 32'(switch_db), 32'd1);
    chk({nm, "_idle_vld"}, 32'(addr_valid), 32'd0);
    chk({nm, "_final_cnt"}, xfer_cnt, 32'(v.exp_count));
    chk({nm, "_last_addr"}, 32'(last_addr), 32'(v.exp_last));
    if (v.freeze_at >= 0) begin
      clk_en = 0;
      tick(); tick();
      chk({nm, "_done_held"}, 32'(done), 32'd1);
      chk({nm, "_switch_held"}, 32'(switch_db), 32'd1);
      clk_en = 1;
    end
    tick();
    chk({nm, "_done_pulse_end"}, 32'(done), 32'd0);
    chk({nm, "_switch_pulse_end"}, 32'(switch_db), 32'd0);
    chk({nm, "_idle_vld2"}, 32'(addr_valid), 32'd0);
    chk({nm, "_cnt_hold"}, xfer_cnt, 32'(v.exp_count));
  endtask

  initial begin
    vec_t v;
    reset = 1; clk_en = 1; flush = 0; start = 0; addr_ready = 0;
    starting_addr = '0; dimensionality = '0; stride = '0; rng = '0;

    // Vector table
    tbl[0] = mk(16'h0000, 4'd3, 0, -1, 27, 16'd26);
    tbl[0].str[0] = 1; tbl[0].str[1] = 3; tbl[0].str[2] = 9;
    tbl[0].rg[0]  = 3; tbl[0].rg[1]  = 3; tbl[0].rg[2]  = 3;
    tbl[1] = tbl[0]; tbl[1].mode = 1;
    tbl[2] = mk(16'hFFFE, 4'd1, 0, -1, 4, 16'h0001);
    tbl[2].str[0] = 1; tbl[2].rg[0] = 4;
    tbl[3] = mk(16'h1234, 4'd1, 0, -1, 1, 16'h1234);
    tbl[3].str[0] = 7; tbl[3].rg[0] = 0;
    tbl[4] = mk(16'h0100, 4'd0, 2, -1, 5, 16'h0108);
    tbl[4].str[0] = 2; tbl[4].str[1] = 16'h55; tbl[4].rg[0] = 5; tbl[4].rg[1] = 7;
    tbl[5] = mk(16'h0000, 4'd9, 2, -1, 64, 16'h003F);
    for (int i = 0; i < 6; i++) begin tbl[5].str[i] = 16'(1 << i); tbl[5].rg[i] = 2; end
    tbl[6] = mk(16'h0200, 4'd2, 1, -1, 3, 16'h0220);
    tbl[6].str[0] = 5; tbl[6].str[1] = 16'h10; tbl[6].rg[0] = 1; tbl[6].rg[1] = 3;
    tbl[7] = mk(16'h0000, 4'd2, 0, -1, 4, 16'h0101);
    tbl[7].str[0] = 1; tbl[7].str[1] = 16'h100; tbl[7].str[2] = 7; tbl[7].str[3] = 7;
    tbl[7].rg[0] = 2; tbl[7].rg[1] = 2; tbl[7].rg[2] = 5; tbl[7].rg[3] = 5;
    tbl[8] = tbl[0]; tbl[8].freeze_at = 4;

    // Reset state
    tick(); tick();
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_vld", 32'(addr_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_switch", 32'(switch_db), 32'd0);
    chk("rst_cnt", xfer_cnt, 32'd0);
    reset = 0;
    tick();

    for (int t = 0; t < 9; t++)
      run_pattern(tbl[t], $sformatf("tbl%0d", t));

    // Flush after the 5th transfer, flush beats transfer and start
    apply_cfg(tbl[0]);
    start = 1; tick(); start = 0;
    addr_ready = 1;
    repeat (5) tick();
    chk("fl_addr5", 32'(addr_out), 32'd5);
    flush = 1; start = 1;
    tick();
    flush = 0; start = 0; addr_ready = 0;
    chk("fl_vld", 32'(addr_valid), 32'd0);
    chk("fl_done", 32'(done), 32'd0);
    chk("fl_switch", 32'(switch_db), 32'd0);
    chk("fl_cnt", xfer_cnt, 32'd5);
    tick();
    chk("fl_done2", 32'(done), 32'd0);
    chk("fl_cnt2", xfer_cnt, 32'd5);
    starting_addr = 16'h0040;
    start = 1; tick(); start = 0;
    chk("fl_restart_vld", 32'(addr_valid), 32'd1);
    chk("fl_restart_addr", 32'(addr_out), 32'h40);
    chk("fl_restart_cnt", xfer_cnt, 32'd0);
    flush = 1; start = 1; tick();
    chk("fl_run_idle", 32'(addr_valid), 32'd0);
    tick();
    flush = 0; start = 0;
    chk("fl_wins_start", 32'(addr_valid), 32'd0);

    // Reset mid-pattern, with clk_en low
    apply_cfg(tbl[0]);
    start = 1; tick(); start = 0;
    addr_ready = 1;
    repeat (4) tick();
    clk_en = 0; reset = 1;
    tick();
    reset = 0; clk_en = 1; addr_ready = 0;
    chk("mr_addr", 32'(addr_out), 32'd0);
    chk("mr_vld", 32'(addr_valid), 32'd0);
    chk("mr_cnt", xfer_cnt, 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    tick();
    chk("mr_done2", 32'(done), 32'd0);
    chk("mr_switch2", 32'(switch_db), 32'd0);
    run_pattern(tbl[0], "after_rst");

    // Random patterns against the reference model
    for (int n = 0; n < 20; n++) begin
      int lim;
      v = mk(16'($urandom), 4'($urandom_range(0, 9)), $urandom_range(0, 2), -1, 0, '0);
      if (n % 5 == 0) v.freeze_at = 1;
      lim = (m_dims(v) <= 3) ? 4 : 2;
      for (int i = 0; i < 6; i++) begin
        v.str[i] = 16'($urandom);
        v.rg[i]  = $urandom_range(0, lim);
      end
      if (v.freeze_at >= m_total(v)) v.freeze_at = 0;
      v.exp_count = m_total(v);
      v.exp_last  = m_addr(v, v.exp_count - 1);
      run_pattern(v, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/db_addr_gen.md
DB_ADDR_GEN -- requirements
Module: db_addr_gen

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; one clock, reset synchronous active-high.
REQ-003 SHALL have ports: clk_en  in  1  global enable; state frozen when 0.
REQ-004 SHALL have ports: flush  in  1  abort current pattern, return to IDLE.
REQ-005 SHALL have ports: start  in  1  latch config and begin pattern.
REQ-006 SHALL have ports: starting_addr  in  16  base address.
REQ-007 SHALL have ports: dimensionality  in  4  active loop dims (0 means 1; >6 means 6).
REQ-008 SHALL have ports: stride  in  6x16  per-dim stride, dim 0 innermost.
REQ-009 SHALL have ports: range  in  6x32  per-dim trip count (0 means 1).
REQ-010 SHALL have ports: addr_out  out  16  current address.
REQ-011 SHALL have ports: addr_valid  out  1  addr_out valid.
REQ-012 SHALL have ports: addr_ready  in  1  consumer (memory core read port) accepts.
REQ-013 SHALL have ports: done  out  1  one-cycle pulse after last accepted address.
REQ-014 SHALL have ports: switch_db  out  1  one-cycle pulse, coincident with done, to flip double-buffer bank.
REQ-015 SHALL have ports: xfer_cnt  out  32  addresses accepted in current/last pattern.

Function
REQ-016 SHALL implement FSM IDLE, RUN; transitions qualified by clk_en.
REQ-017 IDLE + start: latch all config, clear dim counters and offset accumulators, xfer_cnt=0; next cycle RUN with addr_valid=1, addr_out=starting_addr.
REQ-018 RUN: start ignored; config inputs ignored (latched copy used).
REQ-019 Handshake: transfer when addr_valid && addr_ready && clk_en; addr_out/addr_valid SHALL hold stable while addr_valid && !addr_ready.
REQ-020 On transfer: cnt[0]++; if cnt[i] reaches range[i]-1 it wraps to 0 and carries into dim i+1; dims >= dimensionality have effective range 1.
REQ-021 addr_out SHALL equal starting_addr + sum(cnt[i]*stride[i]) mod 2^16, maintained incrementally with per-dim offset accumulators (no multipliers); next address registered, zero-bubble back-to-back.
REQ-022 Last transfer (all active dims at range-1): next cycle IDLE, addr_valid=0, done=1, switch_db=1 for exactly one cycle.
REQ-023 xfer_cnt increments per transfer, 32-bit wrap; holds value in IDLE until next start.
REQ-024 flush (clk_en=1) in any state: next cycle IDLE, addr_valid=0, no done/switch_db pulse; flush wins over start and transfer in same cycle.
REQ-025 clk_en=0: no state, counter, or output-register change; done/switch_db pulses extend until next enabled edge.
REQ-026 Start and last-transfer in same cycle: start ignored (FSM still RUN).

Reset
REQ-027 reset SHALL force IDLE, addr_out=0, addr_valid=0, done=0, switch_db=0, xfer_cnt=0, counters/accumulators 0, regardless of clk_en; mid-pattern reset discards pattern, no done pulse.

Structure
REQ-028 Shared package SHALL hold NUM_DIMS=6, ADDR_W=16, RANGE_W=32, stride/range array typedefs, FSM state enum.
REQ-029 One sub-module db_dim_counter (one dim: count, wrap flag, offset accumulator), instantiated NUM_DIMS times with carry chain.

Verification
REQ-030 start=0, strides 1/3/9, ranges 3/3/3, dim=3, ready=1 -> addr_out 0,1,...,26 on consecutive cycles; done+switch_db one cycle after 27th; xfer_cnt=27.
REQ-031 Same config, ready toggling 1,0 -> identical sequence, addr held during stalls, done after 27 transfers.
REQ-032 starting_addr=0xFFFE, stride0=1, range0=4, dim=1 -> FFFE,FFFF,0000,0001, then done.
REQ-033 range0=0, dim=1 -> exactly one address (starting_addr) then done; dim=0 behaves as dim=1.
REQ-034 flush after 5th transfer -> IDLE next cycle, no done, xfer_cnt=5; new start restarts at starting_addr.
REQ-035 reset during RUN, and clk_en=0 for 3 cycles mid-pattern -> reset values per REQ-027; freeze leaves addr_out/xfer_cnt unchanged, sequence resumes intact.
